// File: rtl/ones_pkg.sv
// Shared definitions for the ones-fill and popcount FSMD pair.
package ones_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // k_sel encoding: load a new count, or step the remaining count down
  localparam logic K_SEL_DEC  = 1'b0;
  localparam logic K_SEL_LOAD = 1'b1;

  function automatic int count_width(int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/ones_fill_datapath.sv
// Datapath for ones_fill_fsmd: remaining count, word under construction, range flag.
// ONES_FILL_SATURATE_EN clamps oversize counts instead of flagging them.
module ones_fill_datapath
  import ones_pkg::*;
#(
  parameter int INPUT_WIDTH = 32,
  parameter int COUNT_WIDTH = count_width(INPUT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COUNT_WIDTH-1:0] count_in,
  input  logic                   k_en,
  input  logic                   k_sel,
  input  logic                   w_en,
  input  logic                   w_clr,
  input  logic                   done,
  output logic                   k_eq_0,
  output logic [INPUT_WIDTH-1:0] out,
  output logic                   err
);

  logic [COUNT_WIDTH-1:0] k_q, k_d, k_load;
  logic [INPUT_WIDTH-1:0] w_q, w_d;
  logic                   err_q, err_d, err_load, over;

  always_comb begin
    over     = count_in > COUNT_WIDTH'(INPUT_WIDTH);
    k_load   = count_in;
    err_load = 1'b0;
`ifdef ONES_FILL_SATURATE_EN
    if (over) k_load = COUNT_WIDTH'(INPUT_WIDTH);
`else
    // an oversize request completes immediately with an empty word
    if (over) begin
      k_load   = '0;
      err_load = 1'b1;
    end
`endif
  end

  always_comb begin
    k_d   = k_q;
    w_d   = w_q;
    err_d = err_q;
    if (k_en) k_d = (k_sel == K_SEL_LOAD) ? k_load : k_q - COUNT_WIDTH'(1);
    if (w_clr) begin
      w_d   = '0;
      err_d = err_load;
    end else if (w_en) begin
      w_d = {w_q[INPUT_WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q   <= '0;
      w_q   <= '0;
      err_q <= 1'b0;
    end else begin
      k_q   <= k_d;
      w_q   <= w_d;
      err_q <= err_d;
    end
  end

  assign k_eq_0 = (k_q == '0);
  assign out    = done ? w_q : '0;
  assign err    = done & err_q;

endmodule

// File: rtl/ones_fill_fsmd.sv
// Iterative fill: builds a word with k low bits set, one bit per cycle.
// Build option ONES_FILL_SATURATE_EN clamps counts above INPUT_WIDTH (see datapath).
module ones_fill_fsmd
  import ones_pkg::*;
#(
  parameter  int INPUT_WIDTH = 32,
  localparam int COUNT_WIDTH = count_width(INPUT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic [COUNT_WIDTH-1:0] count_in,
  output logic [INPUT_WIDTH-1:0] out,
  output logic                   done,
  output logic                   busy,
  output logic                   err
);

  state_e state_q, state_d;
  logic   k_en, k_sel, w_en, w_clr, k_eq_0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    k_en    = 1'b0;
    k_sel   = K_SEL_DEC;
    w_en    = 1'b0;
    w_clr   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (go) begin
          k_en    = 1'b1;
          k_sel   = K_SEL_LOAD;
          w_clr   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // go is ignored here; count_in is only sampled on load
        if (!k_eq_0) begin
          k_en = 1'b1;
          w_en = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done = (state_q == DONE);
  assign busy = (state_q == BUSY);

  ones_fill_datapath #(
    .INPUT_WIDTH(INPUT_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .count_in(count_in),
    .k_en    (k_en),
    .k_sel   (k_sel),
    .w_en    (w_en),
    .w_clr   (w_clr),
    .done    (done),
    .k_eq_0  (k_eq_0),
    .out     (out),
    .err     (err)
  );

endmodule

// File: tb/tb_ones_fill_fsmd.sv
// Directed self-checking bench for ones_fill_fsmd.
module tb_ones_fill_fsmd;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [5:0]  count_in;
  logic [31:0] out;
  logic        done, busy, err;

  int n_cmp = 0;
  int n_err = 0;

  ones_fill_fsmd dut (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .count_in(count_in),
    .out     (out),
    .done    (done),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drive go for one edge (E0); returns at E0+#1 with go released
  task automatic start(input int k);
    @(negedge clk);
    go       = 1'b1;
    count_in = 6'(k);
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  // counts edges after E0 until done is seen, bounded
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  int          cyc;
  logic [31:0] held;
  logic [63:0] mask;

  initial begin
    rst = 1'b0; go = 1'b0; count_in = '0;
    #17;
    chk("rst_out", out, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(negedge clk); rst = 1'b1;

    // k = 5
    start(5);
    chk("k5_busy_e0", busy, 1);
    chk("k5_done_e0", done, 0);
    wait_done(cyc);
    chk("k5_lat", cyc, 6);
    chk("k5_out", out, 32'h0000_001F);
    chk("k5_err", err, 0);
    chk("k5_busy_end", busy, 0);
    held = out;
    repeat (3) @(posedge clk);
    #1;
    chk("k5_hold_out", out, {32'h0, held});
    chk("k5_hold_done", done, 1);

    // k = 0
    start(0);
    chk("k0_done_e0", done, 0);
    wait_done(cyc);
    chk("k0_lat", cyc, 1);
    chk("k0_out", out, 0);

    // k = 32
    start(32);
    wait_done(cyc);
    chk("k32_lat", cyc, 33);
    chk("k32_out", out, 32'hFFFF_FFFF);
    chk("k32_err", err, 0);

    // k = 40 (out of range)
    start(40);
    wait_done(cyc);
`ifdef ONES_FILL_SATURATE_EN
    chk("k40_lat", cyc, 33);
    chk("k40_out", out, 32'hFFFF_FFFF);
    chk("k40_err", err, 0);
`else
    chk("k40_lat", cyc, 1);
    chk("k40_out", out, 0);
    chk("k40_err", err, 1);
`endif

    // go while busy is ignored
    start(3);
    @(posedge clk); #1;
    @(negedge clk); go = 1'b1; count_in = 6'd20;
    @(posedge clk); #1; go = 1'b0;
    wait_done(cyc);
    chk("ign_lat", cyc, 2);
    chk("ign_out", out, 32'h0000_0007);

    // restart straight from DONE
    start(2);
    chk("re_done_e0", done, 0);
    chk("re_out_e0", out, 0);
    wait_done(cyc);
    chk("re_lat", cyc, 3);
    chk("re_out", out, 32'h0000_0003);

    // async reset mid-operation
    start(10);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_out", out, 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle_busy", busy, 0);
    start(1);
    wait_done(cyc);
    chk("post_rst_lat", cyc, 2);
    chk("post_rst_out", out, 32'h0000_0001);

    // closed loop against a popcount model
    for (int k = 0; k <= 32; k++) begin
      start(k);
      wait_done(cyc);
      mask = (64'd1 << k) - 64'd1;
      chk($sformatf("loop_out_k%0d", k), out, mask);
      chk($sformatf("loop_pop_k%0d", k), $countones(out), k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ones_fill_fsmd.md
# ones_fill_fsmd

Iterative fill block: given a count k, builds an INPUT_WIDTH-bit word whose k least-significant bits are set, one bit per cycle. It is the inverse of the team's popcount FSMD, which strips one set bit per cycle via n & (n-1). This block appends one set bit per cycle via (w << 1) | 1. Both blocks share the go/done handshake and output gating, so they can be chained for closed-loop tests and pattern generation.

## Interface
- INPUT_WIDTH, 32, width of the generated word (matches the popcount input width)
- COUNT_WIDTH, $clog2(INPUT_WIDTH+1), localparam: width of the count field
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset (assert at 0; deassertion is synchronised outside this block)
- go  input  1  start request, sampled at a rising edge
- count_in  input  COUNT_WIDTH  requested number of ones k, sampled with go
- out  output  INPUT_WIDTH  generated word; reads 0 whenever done=0
- done  output  1  result valid; held until the next accepted go
- busy  output  1  operation in progress
- err  output  1  out-of-range count flag; valid while done=1

## Operation
- States:
  - IDLE: reset state; waits for go.
  - BUSY: one shift per cycle.
  - DONE: result held.
- Registers:
  - k_r (COUNT_WIDTH): remaining ones to append.
  - w_r (INPUT_WIDTH): word under construction.
  - err_r: out-of-range flag.
- IDLE or DONE, go=1:
  - Load k_r = count_in, w_r = 0, err_r = 0; next state BUSY.
  - Range handling for count_in > INPUT_WIDTH is defined under Configuration.
- BUSY, k_r != 0: w_r <= (w_r << 1) | 1; k_r <= k_r - 1.
- BUSY, k_r == 0: next state DONE; w_r unchanged.
- DONE, go=0: hold all registers.
- go in BUSY: ignored; count_in is not sampled.
- Outputs:
  - out = done ? w_r : '0
  - done = (state == DONE)
  - busy = (state == BUSY)
  - err = done & err_r
- Arithmetic:
  - k_r decrements only while nonzero, so it never wraps.
  - w_r never holds more than INPUT_WIDTH ones, so the shift never drops a set bit.

## Timing
- Reset (rst=0): state IDLE, k_r=0, w_r=0, err_r=0. Outputs: out=0, done=0, busy=0, err=0. Takes effect immediately (asynchronous), including mid-operation; the in-flight result is discarded.
- go accepted at edge E0: busy=1 after E0. For k in range, done=1 after edge E0+k+1.
- k=0: done after E0+1 with out=0.
- DONE with go=1 at edge E: done falls after E; a new operation starts with no idle cycle.
- done and out are stable across every cycle with go=0.

## Configuration
- Macro ONES_FILL_SATURATE_EN.
- Defined: count_in > INPUT_WIDTH is clamped to INPUT_WIDTH at load. The result is all ones, latency is INPUT_WIDTH+1, and err is tied to 0.
- Undefined: count_in > INPUT_WIDTH sets err_r=1 and loads k_r=0. done rises after E0+1 with out=0 and err=1.
- Counts 0..INPUT_WIDTH behave identically in both builds.

## Structure
- Shared package ones_pkg:
  - state typedef: enum logic [1:0] {IDLE, BUSY, DONE}.
  - count_width(int w) function returning $clog2(w+1). The popcount block reuses it.
- Top module ones_fill_fsmd contains the FSM.
- Sub-module ones_fill_datapath holds k_r, w_r, err_r, the clamp/range logic and output gating. It is driven by k_en, k_sel, w_en and w_clr, and returns k_eq_0. This is the same controller/datapath split as the popcount block.

## Test plan
- Reset, then go with count_in=5 at edge E0: busy high over edges E0..E0+5; done=1 after E0+6; out=0x0000001F; err=0; out held while go=0.
- count_in=0: done after one cycle, out=0x00000000. count_in=32: done after 33 cycles, out=0xFFFFFFFF.
- count_in=40:
  - with ONES_FILL_SATURATE_EN: out=0xFFFFFFFF, err=0.
  - without it: done after one cycle, out=0, err=1.
- go with count_in=3, then go with count_in=20 two cycles later (while busy): second request ignored; result 0x00000007. Re-issue go in DONE with count_in=2: done drops for 3 cycles, then out=0x00000003.
- Drive rst=0 while count_in=10 is mid-operation: outputs immediately 0 and state IDLE. After release, a fresh go with count_in=1 yields 0x00000001.
- Closed loop: feed out into the popcount FSMD for every k in 0..32. The recovered count must equal k.
